alu_ctrl_issue: RTL and testbench

- Generates the 4-bit ALUOp encoding consumed by the 64-bit datapath ALU. It is the encoder side of the ALUOp/Zero/Is_Greater interface.
- Accepts decoded instruction fields from the decode stage over a valid/ready handshake.
- Emits the ALU operation code, a branch-condition select and an illegal flag through a registered output stage with a one-entry skid buffer.
- Sits between instruction decode and execute; it sustains one operation per cycle under backpressure.

---
 rtl/alu_ctrl_issue_if.sv | 37 +++
 rtl/alu_ctrl_issue.sv | 178 +++++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_issue_if.sv
// ---------------------------------------------------------------------------
// alu_ctrl_issue_if
// Bundles the decode-side and execute-side handshakes of alu_ctrl_issue.
//
// Decode side : in_valid, in_ready, op_type[1:0], funct3[2:0], funct7_b5
// Execute side: out_valid, out_ready, alu_op[3:0], br_cond[2:0], illegal
// Status      : illegal_cnt[CNT_W-1:0]
//
// Modports:
//   master - the environment (drives decode fields and out_ready)
//   slave  - the ALU control issue block
// ---------------------------------------------------------------------------
interface alu_ctrl_issue_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op_type;
   logic [2:0]       funct3;
   logic             funct7_b5;
   logic             out_valid;
   logic             out_ready;
   logic [3:0]       alu_op;
   logic [2:0]       br_cond;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, op_type, funct3, funct7_b5, out_ready,
      input  in_ready, out_valid, alu_op, br_cond, illegal, illegal_cnt
   );

   modport slave (
      input  in_valid, op_type, funct3, funct7_b5, out_ready,
      output in_ready, out_valid, alu_op, br_cond, illegal, illegal_cnt
   );
endinterface

// File: rtl/alu_ctrl_issue.sv
// ---------------------------------------------------------------------------
// alu_ctrl_issue
// Encodes decoded instruction fields into the 4-bit ALUOp, a branch-condition
// select and an illegal flag, delivered through a registered output stage
// backed by a one-entry skid buffer so one word per cycle is sustained.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - alu_ctrl_issue_if.slave
//              in_valid/in_ready + op_type, funct3, funct7_b5 (decode side)
//              out_valid/out_ready + alu_op, br_cond, illegal (execute side)
//              illegal_cnt: saturating count of accepted illegal words
// ---------------------------------------------------------------------------
module alu_ctrl_issue #(
   parameter int CNT_W = 8
) (
   input logic             clk,
   input logic             reset_n,
   alu_ctrl_issue_if.slave bus
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLL = 4'b0111;

   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_GTU  = 3'b011;
   localparam logic [2:0] BR_LEU  = 3'b100;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [2:0] br_cond;
      logic       illegal;
   } word_t;

   localparam word_t RESET_WORD = '{alu_op: ALU_ADD, br_cond: BR_NONE, illegal: 1'b0};

   // EMPTY: nothing held; OUT: output register full; FULL: output + skid full
   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_OUT,
      ST_FULL
   } state_t;

   state_t           state_q, state_d;
   word_t            out_q, out_d;
   word_t            skid_q, skid_d;
   word_t            dec_word;
   logic             in_ready_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             drain;

   assign accept = bus.in_valid & in_ready_q;
   assign drain  = (state_q != ST_EMPTY) & bus.out_ready;

   // Field decode; an unsupported combination collapses to ADD/none/illegal.
   always_comb begin
      dec_word = '{alu_op: ALU_ADD, br_cond: BR_NONE, illegal: 1'b0};
      case (bus.op_type)
         2'b00: begin
            dec_word.alu_op = ALU_ADD;
         end
         2'b01: begin
            dec_word.alu_op = ALU_SUB;
            case (bus.funct3)
               3'b000:  dec_word.br_cond = BR_EQ;
               3'b001:  dec_word.br_cond = BR_NE;
               3'b100:  dec_word.br_cond = BR_GTU;
               3'b101:  dec_word.br_cond = BR_LEU;
               default: dec_word.illegal = 1'b1;
            endcase
         end
         2'b10: begin
            case ({bus.funct3, bus.funct7_b5})
               4'b000_0: dec_word.alu_op = ALU_ADD;
               4'b000_1: dec_word.alu_op = ALU_SUB;
               4'b111_0: dec_word.alu_op = ALU_AND;
               4'b110_0: dec_word.alu_op = ALU_OR;
               4'b001_0: dec_word.alu_op = ALU_SLL;
               4'b100_1: dec_word.alu_op = ALU_NOR;
               default:  dec_word.illegal = 1'b1;
            endcase
         end
         default: begin
            case (bus.funct3)
               3'b000:  dec_word.alu_op = ALU_ADD;
               3'b111:  dec_word.alu_op = ALU_AND;
               3'b110:  dec_word.alu_op = ALU_OR;
               3'b001: begin
                  if (bus.funct7_b5) dec_word.illegal = 1'b1;
                  else               dec_word.alu_op  = ALU_SLL;
               end
               default: dec_word.illegal = 1'b1;
            endcase
         end
      endcase
      if (dec_word.illegal) begin
         dec_word.alu_op  = ALU_ADD;
         dec_word.br_cond = BR_NONE;
      end
   end

   // Occupancy FSM: decides where an accepted word lands and when the skid
   // word is promoted. FULL never accepts because in_ready is low there.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_d   = dec_word;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (accept && drain) begin
               out_d = dec_word;
            end else if (accept) begin
               skid_d  = dec_word;
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               out_d   = skid_q;
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Illegal words are counted when accepted, saturating at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (accept && dec_word.illegal && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; in_ready is registered from the next occupancy so it
   // never depends combinationally on out_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_EMPTY;
         out_q      <= RESET_WORD;
         skid_q     <= RESET_WORD;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != ST_FULL);
         cnt_q      <= cnt_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = (state_q != ST_EMPTY);
   assign bus.alu_op      = out_q.alu_op;
   assign bus.br_cond     = out_q.br_cond;
   assign bus.illegal     = out_q.illegal;
   assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_issue
// Self-checking bench for alu_ctrl_issue. A queue-based reference model
// tracks accepted words and the illegal counter; a compare process checks
// the DUT against it every cycle, and directed sequences pin literal values.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_issue;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   alu_ctrl_issue_if #(.CNT_W(CNT_W)) bus ();

   alu_ctrl_issue #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Accepted but not yet delivered words, packed {alu_op, br_cond, illegal}
   logic [7:0] model_q[$];
   int         model_cnt = 0;

   // Reference decode written as a list of the legal mnemonics.
   function automatic logic [7:0] ref_word(input logic [1:0] ot, input logic [2:0] f3, input logic b5);
      logic [3:0] op;
      logic [2:0] br;
      logic       legal;
      op    = 4'b0010;
      br    = 3'b000;
      legal = 1'b0;
      if (ot == 2'd0) begin
         legal = 1'b1;
      end else if (ot == 2'd1) begin
         op    = 4'b0110;
         legal = 1'b1;
         if      (f3 == 3'd0) br = 3'b001;
         else if (f3 == 3'd1) br = 3'b010;
         else if (f3 == 3'd4) br = 3'b011;
         else if (f3 == 3'd5) br = 3'b100;
         else                 legal = 1'b0;
      end else if (ot == 2'd2) begin
         if (f3 == 3'd0)                begin legal = 1'b1; op = b5 ? 4'b0110 : 4'b0010; end
         else if (f3 == 3'd7 && !b5)    begin legal = 1'b1; op = 4'b0000; end
         else if (f3 == 3'd6 && !b5)    begin legal = 1'b1; op = 4'b0001; end
         else if (f3 == 3'd1 && !b5)    begin legal = 1'b1; op = 4'b0111; end
         else if (f3 == 3'd4 &&  b5)    begin legal = 1'b1; op = 4'b1100; end
      end else begin
         if      (f3 == 3'd0)           begin legal = 1'b1; op = 4'b0010; end
         else if (f3 == 3'd7)           begin legal = 1'b1; op = 4'b0000; end
         else if (f3 == 3'd6)           begin legal = 1'b1; op = 4'b0001; end
         else if (f3 == 3'd1 && !b5)    begin legal = 1'b1; op = 4'b0111; end
      end
      if (!legal) return {4'b0010, 3'b000, 1'b1};
      return {op, br, 1'b0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkWord(input string name, input logic [3:0] op, input logic [2:0] br, input logic ill);
      checkOutput({name, "_valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({name, "_word"}, 32'({bus.alu_op, bus.br_cond, bus.illegal}), 32'({op, br, ill}));
   endtask

   // Inputs change 1 time unit after the rising edge and hold until the next.
   task automatic applyStimulus(input logic v, input logic [1:0] ot, input logic [2:0] f3,
                                input logic b5, input logic ordy);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.op_type   = ot;
      bus.funct3    = f3;
      bus.funct7_b5 = b5;
      bus.out_ready = ordy;
   endtask

   // Compare process: check the DUT against the model, then advance the model
   // across the coming rising edge using the stable inputs.
   always @(negedge clk) begin : model_proc
      logic m_accept;
      logic m_drain;
      logic [7:0] w;
      if (!reset_n) begin
         model_q.delete();
         model_cnt = 0;
      end
      checkOutput("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
      checkOutput("in_ready", 32'(bus.in_ready), 32'(model_q.size() < 2));
      checkOutput("illegal_cnt", 32'(bus.illegal_cnt), 32'(model_cnt));
      if (model_q.size() > 0) begin
         checkOutput("out_word", 32'({bus.alu_op, bus.br_cond, bus.illegal}), 32'(model_q[0]));
      end
      if (reset_n) begin
         m_drain  = (model_q.size() > 0) && bus.out_ready;
         m_accept = bus.in_valid && (model_q.size() < 2);
         if (m_drain) void'(model_q.pop_front());
         if (m_accept) begin
            w = ref_word(bus.op_type, bus.funct3, bus.funct7_b5);
            model_q.push_back(w);
            if (w[0] && model_cnt < CNT_MAX) model_cnt++;
         end
      end
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.op_type   = 2'b00;
      bus.funct3    = 3'b000;
      bus.funct7_b5 = 1'b0;
      bus.out_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_alu_op", 32'(bus.alu_op), 32'h2);
      checkOutput("rst_br_cond", 32'(bus.br_cond), 32'h0);
      checkOutput("rst_illegal", 32'(bus.illegal), 32'h0);
      checkOutput("rst_cnt", 32'(bus.illegal_cnt), 32'h0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);

      // Single R-type SUB, latency one
      applyStimulus(1'b1, 2'b10, 3'b000, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      checkWord("sub", 4'b0110, 3'b000, 1'b0);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);

      // Back-to-back LW, BEQ, OR, SLLI, NOR
      begin
         logic [1:0] ots[5];
         logic [2:0] f3s[5];
         logic       b5s[5];
         logic [7:0] exp_w[5];
         ots = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
         f3s = '{3'b011, 3'b000, 3'b110, 3'b001, 3'b100};
         b5s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
         exp_w = '{8'b0010_000_0, 8'b0110_001_0, 8'b0001_000_0, 8'b0111_000_0, 8'b1100_000_0};
         for (int k = 0; k <= 5; k++) begin
            if (k < 5) applyStimulus(1'b1, ots[k], f3s[k], b5s[k], 1'b1);
            else       applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
            @(negedge clk);
            if (k >= 1) checkWord("stream", exp_w[k-1][7:4], exp_w[k-1][3:1], exp_w[k-1][0]);
         end
      end
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);

      // Backpressure: AND held, SUB in skid, ORI waits
      applyStimulus(1'b1, 2'b10, 3'b111, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 3'b000, 1'b1, 1'b0);
      @(negedge clk);
      checkWord("bp_first", 4'b0000, 3'b000, 1'b0);
      applyStimulus(1'b1, 2'b11, 3'b110, 1'b0, 1'b0);
      @(negedge clk);
      checkWord("bp_hold", 4'b0000, 3'b000, 1'b0);
      checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      applyStimulus(1'b1, 2'b11, 3'b110, 1'b0, 1'b0);
      @(negedge clk);
      checkWord("bp_hold2", 4'b0000, 3'b000, 1'b0);
      applyStimulus(1'b1, 2'b11, 3'b110, 1'b0, 1'b1);
      applyStimulus(1'b1, 2'b11, 3'b110, 1'b0, 1'b1);
      @(negedge clk);
      checkWord("bp_second", 4'b0110, 3'b000, 1'b0);
      checkOutput("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      checkWord("bp_third", 4'b0001, 3'b000, 1'b0);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);

      // Illegal branch funct3, then saturation
      applyStimulus(1'b1, 2'b01, 3'b010, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      checkWord("illegal", 4'b0010, 3'b000, 1'b1);
      checkOutput("illegal_cnt1", 32'(bus.illegal_cnt), 32'd1);
      repeat (300) applyStimulus(1'b1, 2'b01, 3'b010, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("illegal_sat", 32'(bus.illegal_cnt), 32'd255);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);

      // Asynchronous reset with the skid buffer full
      applyStimulus(1'b1, 2'b10, 3'b111, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 3'b110, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b0);
      checkOutput("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("async_rst_cnt", 32'(bus.illegal_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
         @(negedge clk);
         checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd0);
         checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      end

      // Randomized traffic with random backpressure
      repeat (2000) begin
         applyStimulus(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 9) < 6));
      end
      repeat (4) applyStimulus(1'b0, 2'b00, 3'b000, 1'b0, 1'b1);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
